uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: control block that sits between a UART RX datapath and an audio sink.
// It generates the 16x oversample tick and pairs received bytes into 16-bit samples
// ({high byte, low byte}). A low byte whose high byte never arrives is dropped after a
// tick timeout. Samples are buffered in an 8-deep first-word-fall-through FIFO, and
// error events are counted in a saturating 8-bit counter.
//
// Build option: define UART_RX_CTRL_PARITY_EN to reject bytes flagged with rx_perr.
//
// State | meaning
// S_LO  | waiting for the low byte of a sample
// S_HI  | low byte held, waiting for the high byte (timeout counter running)
module uart_rx_ctrl #(
    parameter int DIV           = 326,
    parameter int TIMEOUT_TICKS = 512
) (
    input  logic        CLK50MHz,
    input  logic        RESET,
    input  logic        ctrl_en,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        rx_perr,
    output logic        tick,
    output logic        rx_en,
    output logic [15:0] smp_data,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [3:0]  fifo_level,
    output logic [7:0]  err_cnt
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic {S_LO, S_HI} state_t;

    state_t        state;
    logic [CW-1:0] div_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    lo_byte;
    logic [15:0]   mem [8];
    logic [2:0]    wr_ptr;
    logic [2:0]    rd_ptr;
    logic [3:0]    count;

    logic accept;
    logic perr_rej;
    logic push_req;
    logic do_push;
    logic overflow;
    logic pop;
    logic full;
    logic to_evt;
    logic err_evt;

`ifndef UART_RX_CTRL_PARITY_EN
    // Parity flag has no effect in this build.
    logic unused_perr;
    assign unused_perr = rx_perr;
`endif

    // Byte qualification, FIFO handshake and error event decode.
    always_comb begin
`ifdef UART_RX_CTRL_PARITY_EN
        accept   = ctrl_en & rx_valid & ~rx_perr;
        perr_rej = ctrl_en & rx_valid & rx_perr;
`else
        accept   = ctrl_en & rx_valid;
        perr_rej = 1'b0;
`endif
        smp_valid  = (count != 4'd0);
        fifo_level = count;
        smp_data   = mem[rd_ptr];
        full       = (count == 4'd8);
        pop        = smp_valid & smp_ready;
        push_req   = (state == S_HI) & accept;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        do_push    = push_req & (~full | pop);
        overflow   = push_req & full & ~pop;
        // A byte arriving on the expiry tick takes priority over the timeout.
        to_evt     = (state == S_HI) & ctrl_en & tick & (to_cnt == TO_LAST) & ~rx_valid;
        err_evt    = to_evt | perr_rej | overflow;
    end

    // Oversample divider and registered copy of the enable.
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            div_cnt <= '0;
            tick    <= 1'b0;
            rx_en   <= 1'b0;
        end else begin
            rx_en <= ctrl_en;
            if (!ctrl_en) begin
                div_cnt <= '0;
                tick    <= 1'b0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
                tick    <= 1'b0;
            end
        end
    end

    // Byte pairing FSM with low-byte timeout.
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            state   <= S_LO;
            lo_byte <= '0;
            to_cnt  <= '0;
        end else if (!ctrl_en) begin
            state   <= S_LO;
            lo_byte <= '0;
            to_cnt  <= '0;
        end else begin
            case (state)
                S_LO: begin
                    if (accept) begin
                        lo_byte <= rx_byte;
                        to_cnt  <= '0;
                        state   <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept || perr_rej || to_evt) begin
                        lo_byte <= '0;
                        state   <= S_LO;
                    end else if (tick) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= S_LO;
            endcase
        end
    end

    // Sample FIFO storage, pointers and occupancy.
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {rx_byte, lo_byte};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturating error counter, one increment per cycle at most.
    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            err_cnt <= '0;
        end else if (err_evt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with DIV=4 and TIMEOUT_TICKS=3.
module tb_uart_rx_ctrl;

    logic        CLK50MHz = 1'b0;
    logic        RESET;
    logic        ctrl_en;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_perr;
    logic        tick;
    logic        rx_en;
    logic [15:0] smp_data;
    logic        smp_valid;
    logic        smp_ready;
    logic [3:0]  fifo_level;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;
    int exp_err = 0;

    uart_rx_ctrl #(.DIV(4), .TIMEOUT_TICKS(3)) dut (
        .CLK50MHz  (CLK50MHz),
        .RESET     (RESET),
        .ctrl_en   (ctrl_en),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_perr   (rx_perr),
        .tick      (tick),
        .rx_en     (rx_en),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .fifo_level(fifo_level),
        .err_cnt   (err_cnt)
    );

    always #10 CLK50MHz = ~CLK50MHz;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] word;
        logic [3:0]  level;
        int          err_inc;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK50MHz);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic p);
        rx_byte  = b;
        rx_valid = 1'b1;
        rx_perr  = p;
        step();
        rx_valid = 1'b0;
        rx_perr  = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] lo, input logic [7:0] hi);
        send(lo, 1'b0);
        send(hi, 1'b0);
    endtask

    task automatic pop1();
        smp_ready = 1'b1;
        step();
        smp_ready = 1'b0;
    endtask

    // Wait until the third tick since the current low byte is visible; leaves time at that cycle.
    task automatic wait_third_tick(output logic found);
        int n;
        n = 0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (tick) begin
                n++;
                if (n == 3) begin
                    found = 1'b1;
                    break;
                end
            end
            step();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"}, 16'(tick), 16'h0);
        chk({tag, "_rx_en"}, 16'(rx_en), 16'h0);
        chk({tag, "_smp_valid"}, 16'(smp_valid), 16'h0);
        chk({tag, "_smp_data"}, smp_data, 16'h0);
        chk({tag, "_level"}, 16'(fifo_level), 16'h0);
        chk({tag, "_err"}, 16'(err_cnt), 16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic found;

        vt[0] = '{8'h01, 8'hA0, 16'hA001, 4'd1, 0};
        vt[1] = '{8'h02, 8'hB1, 16'hB102, 4'd2, 0};
        vt[2] = '{8'h03, 8'hC2, 16'hC203, 4'd3, 0};
        vt[3] = '{8'h04, 8'hD3, 16'hD304, 4'd4, 0};
        vt[4] = '{8'h05, 8'hE4, 16'hE405, 4'd5, 0};
        vt[5] = '{8'h06, 8'hF5, 16'hF506, 4'd6, 0};
        vt[6] = '{8'h07, 8'h06, 16'h0607, 4'd7, 0};
        vt[7] = '{8'h08, 8'h17, 16'h1708, 4'd8, 0};
        vt[8] = '{8'h09, 8'h28, 16'h2809, 4'd8, 1};

        RESET     = 1'b0;
        ctrl_en   = 1'b0;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        rx_perr   = 1'b0;
        smp_ready = 1'b0;
        #25;
        chk_all_zero("reset");

        @(negedge CLK50MHz);
        RESET = 1'b1;
        step();
        ctrl_en = 1'b1;

        // Tick cadence: high on edges 4, 8, 12 after enable, single cycle each.
        for (int n = 1; n <= 12; n++) begin
            step();
            chk($sformatf("tick_c%0d", n), 16'(tick), 16'((n % 4) == 0));
            if (n == 1) chk("rx_en_follow", 16'(rx_en), 16'h1);
        end

        // Basic pair.
        send_pair(8'h34, 8'h12);
        chk("pair_data", smp_data, 16'h1234);
        chk("pair_valid", 16'(smp_valid), 16'h1);
        chk("pair_level", 16'(fifo_level), 16'h1);
        pop1();
        chk("pair_pop_level", 16'(fifo_level), 16'h0);

        // Fill, overflow on the ninth pair, head never moves.
        for (int i = 0; i < 9; i++) begin
            send_pair(vt[i].lo, vt[i].hi);
            exp_err += vt[i].err_inc;
            chk($sformatf("fill%0d_level", i), 16'(fifo_level), 16'(vt[i].level));
            chk($sformatf("fill%0d_head", i), smp_data, vt[0].word);
            chk($sformatf("fill%0d_err", i), 16'(err_cnt), 16'(exp_err));
        end

        // Ninth pair again with a pop on the completing edge.
        send(vt[8].lo, 1'b0);
        rx_byte   = vt[8].hi;
        rx_valid  = 1'b1;
        smp_ready = 1'b1;
        step();
        rx_valid  = 1'b0;
        smp_ready = 1'b0;
        chk("fullpp_level", 16'(fifo_level), 16'h8);
        chk("fullpp_err", 16'(err_cnt), 16'(exp_err));
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d_data", i), smp_data, vt[i].word);
            pop1();
        end
        chk("drain_level", 16'(fifo_level), 16'h0);
        chk("drain_valid", 16'(smp_valid), 16'h0);

        // Timeout: lone low byte is dropped after the third tick.
        send(8'hAA, 1'b0);
        wait_third_tick(found);
        chk("to_tick_seen", 16'(found), 16'h1);
        chk("to_err_before", 16'(err_cnt), 16'(exp_err));
        step();
        exp_err++;
        chk("to_err_after", 16'(err_cnt), 16'(exp_err));
        chk("to_level", 16'(fifo_level), 16'h0);
        send_pair(8'h01, 8'h02);
        chk("to_next_data", smp_data, 16'h0201);
        chk("to_next_level", 16'(fifo_level), 16'h1);
        pop1();

        // High byte arriving on the expiry tick wins over the timeout.
        send(8'hBB, 1'b0);
        wait_third_tick(found);
        chk("coll_tick_seen", 16'(found), 16'h1);
        send(8'hCC, 1'b0);
        chk("coll_err", 16'(err_cnt), 16'(exp_err));
        chk("coll_data", smp_data, 16'hCCBB);
        chk("coll_level", 16'(fifo_level), 16'h1);
        pop1();
        send_pair(8'h11, 8'h22);
        chk("coll_next_data", smp_data, 16'h2211);
        pop1();

`ifdef UART_RX_CTRL_PARITY_EN
        send(8'h10, 1'b0);
        send(8'h20, 1'b1);
        exp_err++;
        chk("perr_err", 16'(err_cnt), 16'(exp_err));
        chk("perr_level", 16'(fifo_level), 16'h0);
        send_pair(8'h30, 8'h40);
        chk("perr_next_data", smp_data, 16'h4030);
        chk("perr_next_level", 16'(fifo_level), 16'h1);
        pop1();
`else
        send(8'h10, 1'b0);
        send(8'h20, 1'b1);
        chk("noperr_data", smp_data, 16'h2010);
        chk("noperr_level", 16'(fifo_level), 16'h1);
        chk("noperr_err", 16'(err_cnt), 16'(exp_err));
        pop1();
`endif

        // Disable discards the held low byte and ignores strobes.
        send(8'h55, 1'b0);
        ctrl_en = 1'b0;
        step();
        send(8'h99, 1'b0);
        chk("dis_level", 16'(fifo_level), 16'h0);
        chk("dis_rx_en", 16'(rx_en), 16'h0);
        ctrl_en = 1'b1;
        send_pair(8'h66, 8'h77);
        chk("dis_next_data", smp_data, 16'h7766);
        ctrl_en = 1'b0;
        pop1();
        chk("dis_pop_level", 16'(fifo_level), 16'h0);
        ctrl_en = 1'b1;
        step();

        // Error counter saturation via repeated overflow.
        for (int i = 0; i < 8; i++) send_pair(8'(i), 8'hF0);
        while (exp_err < 254) begin
            send_pair(8'hAB, 8'hCD);
            exp_err++;
        end
        chk("sat_254", 16'(err_cnt), 16'd254);
        send_pair(8'hAB, 8'hCD);
        chk("sat_255", 16'(err_cnt), 16'd255);
        send_pair(8'hAB, 8'hCD);
        chk("sat_hold", 16'(err_cnt), 16'd255);
        chk("sat_level", 16'(fifo_level), 16'h8);
        chk("sat_head", smp_data, 16'hF000);

        smp_ready = 1'b1;
        repeat (8) step();
        smp_ready = 1'b0;
        chk("sat_drain_level", 16'(fifo_level), 16'h0);

        // Reset mid-pair with three words buffered.
        send_pair(8'hA1, 8'hB1);
        send_pair(8'hA2, 8'hB2);
        send_pair(8'hA3, 8'hB3);
        chk("rst_pre_level", 16'(fifo_level), 16'h3);
        send(8'hE1, 1'b0);
        #4;
        RESET = 1'b0;
        #1;
        chk_all_zero("rst_async");
        exp_err = 0;
        @(negedge CLK50MHz);
        RESET = 1'b1;
        step();
        send_pair(8'h05, 8'h06);
        chk("rst_next_data", smp_data, 16'h0605);
        chk("rst_next_level", 16'(fifo_level), 16'h1);
        chk("rst_next_err", 16'(err_cnt), 16'(exp_err));
        pop1();
        chk("rst_final_level", 16'(fifo_level), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
